// File: rtl/pipeline_fifo.sv
// Elastic FIFO that uses the valid/backpressure token handshake. Every output
// is taken from registers, so no combinational path runs from input to output.
module pipeline_fifo #(
   parameter int unsigned Width      = 8,
   parameter int unsigned Depth      = 4,
   parameter int unsigned AlmostFull = Depth - 1
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [Width-1:0]           d,
   input  logic                       d_valid,
   output logic                       d_bp,
   output logic [Width-1:0]           q,
   output logic                       q_valid,
   input  logic                       q_bp,
   output logic [$clog2(Depth+1)-1:0] count,
   output logic                       almost_full
);

   localparam int unsigned PW = $clog2(Depth);
   localparam int unsigned CW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             incoming, outgoing;

   assign d_bp        = (count_q == CW'(Depth));
   assign q_valid     = (count_q != '0);
   assign q           = mem_q[rd_ptr_q];
   assign count       = count_q;
   assign almost_full = (count_q >= CW'(AlmostFull));

   assign incoming = d_valid & ~d_bp;
   assign outgoing = q_valid & ~q_bp;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (incoming) wr_ptr_d = wr_ptr_q + PW'(1);
      if (outgoing) rd_ptr_d = rd_ptr_q + PW'(1);
      if (incoming && !outgoing)      count_d = count_q + CW'(1);
      else if (outgoing && !incoming) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // The storage array has no reset. Only the pointers and the count define which entries hold valid tokens.
   always_ff @(posedge clk) begin
      if (incoming) mem_q[wr_ptr_q] <= d;
   end

endmodule

// File: tb/tb_pipeline_fifo.sv
// Directed self-checking bench for pipeline_fifo (Width=8, Depth=4, AlmostFull=3).
module tb_pipeline_fifo;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] d;
   logic       d_valid;
   logic       d_bp;
   logic [7:0] q;
   logic       q_valid;
   logic       q_bp;
   logic [2:0] count;
   logic       almost_full;

   int unsigned ncmp = 0;
   int unsigned mism = 0;

   pipeline_fifo #(.Width(8), .Depth(4), .AlmostFull(3)) dut (
      .clk(clk), .resetn(resetn), .d(d), .d_valid(d_valid), .d_bp(d_bp),
      .q(q), .q_valid(q_valid), .q_bp(q_bp), .count(count), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are driven on the falling edge. Outputs are sampled on the falling edge that follows the next rising edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [7:0]  tok [4];
   logic [7:0]  mq  [16];
   int unsigned mc, wi, ri, pushed, popped;
   logic [15:0] bp_pat;
   logic        inc, outg;

   initial begin
      tok[0] = 8'h11; tok[1] = 8'h22; tok[2] = 8'h33; tok[3] = 8'h44;
      resetn = 1'b0; d = 8'h99; d_valid = 1'b1; q_bp = 1'b1;

      // Reset held while upstream offers tokens
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_qvalid", 32'(q_valid), 0);
         chk("rst_dbp",    32'(d_bp),    0);
         chk("rst_count",  32'(count),   0);
         chk("rst_af",     32'(almost_full), 0);
      end
      resetn = 1'b1; d_valid = 1'b0;
      step();
      chk("post_rst_count", 32'(count), 0);
      chk("post_rst_qvalid", 32'(q_valid), 0);

      // Fill while the consumer is stalled
      for (int i = 0; i < 4; i++) begin
         d = tok[i]; d_valid = 1'b1;
         step();
         chk("fill_count", 32'(count), 32'(i + 1));
         chk("fill_af",    32'(almost_full), 32'(i >= 2));
         chk("fill_dbp",   32'(d_bp), 32'(i == 3));
         chk("fill_head",  32'(q), 32'h11);
      end
      d = 8'h55;
      step();
      chk("full_hold_count", 32'(count), 4);
      chk("full_hold_dbp",   32'(d_bp), 1);

      // Drain the FIFO
      d_valid = 1'b0; q_bp = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("drain_qvalid", 32'(q_valid), 1);
         chk("drain_q", 32'(q), 32'(tok[i]));
         step();
      end
      chk("drain_empty", 32'(q_valid), 0);
      chk("drain_count", 32'(count), 0);

      // Full FIFO: a single-cycle release pops one token and refuses the offered one
      q_bp = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = 8'hA1 + 8'(i); d_valid = 1'b1;
         step();
      end
      chk("full2_count", 32'(count), 4);
      d = 8'hB0; q_bp = 1'b0;
      step();
      chk("full2_pop_count", 32'(count), 3);
      chk("full2_pop_dbp",   32'(d_bp), 0);
      chk("full2_pop_head",  32'(q), 32'hA2);
      q_bp = 1'b1;
      step();
      chk("full2_push_count", 32'(count), 4);
      chk("full2_push_dbp",   32'(d_bp), 1);
      d_valid = 1'b0; q_bp = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("full2_drain", 32'(q), (i == 3) ? 32'hB0 : 32'(8'hA2 + 8'(i)));
         step();
      end
      chk("full2_empty", 32'(q_valid), 0);

      // Streaming, one token per cycle in each direction
      q_bp = 1'b0;
      for (int i = 0; i < 16; i++) begin
         d = 8'(i); d_valid = 1'b1;
         step();
         chk("stream_q",      32'(q), 32'(i));
         chk("stream_qvalid", 32'(q_valid), 1);
         chk("stream_count",  32'(count), 1);
         chk("stream_dbp",    32'(d_bp), 0);
      end
      d_valid = 1'b0;
      step();
      chk("stream_empty", 32'(q_valid), 0);

      // Pointer wrap with a fixed irregular stall pattern, checked against a reference queue
      bp_pat = 16'b1011_0011_1110_0101;
      mc = 0; wi = 0; ri = 0; pushed = 0; popped = 0;
      for (int c = 0; c < 40 && popped < 10; c++) begin
         d_valid = (pushed < 10);
         d = 8'hC0 + 8'(pushed);
         q_bp = bp_pat[c % 16];
         inc  = d_valid && (mc != 4);
         outg = (mc != 0) && !q_bp;
         if (inc) begin mq[wi % 16] = d; wi++; pushed++; mc++; end
         if (outg) begin ri++; popped++; mc--; end
         step();
         chk("wrap_count", 32'(count), 32'(mc));
         if (mc != 0) chk("wrap_q", 32'(q), 32'(mq[ri % 16]));
      end
      chk("wrap_popped", 32'(popped), 10);
      d_valid = 1'b0;

      // Asynchronous reset asserted between clock edges
      q_bp = 1'b1;
      d = 8'h61; d_valid = 1'b1; step();
      d = 8'h62; step();
      d_valid = 1'b0;
      chk("arst_pre_count", 32'(count), 2);
      #2 resetn = 1'b0;
      #1;
      chk("arst_qvalid", 32'(q_valid), 0);
      chk("arst_count",  32'(count), 0);
      @(negedge clk);
      resetn = 1'b1; d = 8'hA5; d_valid = 1'b1; q_bp = 1'b0;
      step();
      d_valid = 1'b0;
      chk("arst_new_q",      32'(q), 32'hA5);
      chk("arst_new_qvalid", 32'(q_valid), 1);
      step();
      chk("arst_final_empty", 32'(q_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, mism);
      $finish;
   end

endmodule

// File: doc/pipeline_fifo.md
# pipeline_fifo

Parameterised multi-entry elastic buffer with the same valid/backpressure token handshake as the pipeline registers. It sits directly downstream of a pipeline register or stage controller and absorbs bursts when the consumer stalls. It decouples producer and consumer across a long-latency or bursty boundary, and sustains one token per cycle in each direction. No combinational path exists from `d`/`d_valid` to `q`/`q_valid`, or from `q_bp` to `d_bp`.

## Interface
- Width, 8, data bits per token.
- Depth, 4, number of entries; power of two, ≥ 2.
- AlmostFull, Depth-1, `almost_full` asserts when occupancy ≥ this value; legal range 1..Depth.
- clk  input  1  clock; all state updates on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- d  input  Width  incoming token data.
- d_valid  input  1  upstream offers a token.
- d_bp  output  1  backpressure to upstream; token not accepted while high.
- q  output  Width  head-of-queue data.
- q_valid  output  1  head entry holds a valid token.
- q_bp  input  1  downstream backpressure.
- count  output  $clog2(Depth+1)  current occupancy, 0..Depth.
- almost_full  output  1  `count >= AlmostFull`.

## Operation
- Storage: Depth-entry array, write pointer `wr_ptr`, read pointer `rd_ptr`, each $clog2(Depth) bits. Occupancy is held in register `count`.
- incoming = `d_valid && !d_bp`; outgoing = `q_valid && !q_bp`.
- `d_bp` = (`count == Depth`). It depends only on registered state, never on `q_bp`. A full FIFO refuses input even in a cycle where it drains.
- `q_valid` = (`count != 0`). `q` = `mem[rd_ptr]`. When `q_valid` is 0, `q` is don't-care.
- On incoming: `mem[wr_ptr] <= d` and `wr_ptr` increments.
- On outgoing: `rd_ptr` increments.
- Pointers wrap naturally from Depth-1 to 0 (power-of-two modulo).
- Count update:
  - +1 on incoming only.
  - −1 on outgoing only.
  - unchanged on both or neither.
- Order is strict FIFO; no token is dropped or duplicated.
- Simultaneous incoming and outgoing:
  - When empty: only incoming is possible, since `q_valid` is 0. There is no bypass.
  - When full: only outgoing is possible, since `d_bp` is 1.
  - Otherwise: both occur and `count` holds.
- `d_valid` while `d_bp` is high has no effect. Upstream must hold the token. The FIFO does not check data stability.
- `q_bp` while `q_valid` is 0 is ignored.
- Reset (resetn low, asynchronous): `wr_ptr`, `rd_ptr` and `count` go to 0 immediately, mid-cycle if asserted mid-cycle. Array contents are not reset. In-flight tokens are discarded.

## Timing
- Reset values:
  - `q_valid` 0.
  - `d_bp` 0.
  - `count` 0.
  - `almost_full` 0, provided AlmostFull ≥ 1.
  - `q` undefined.
- All outputs are functions of registers only (Moore).
- Latency: a token accepted on edge N appears on `q` with `q_valid` = 1 after edge N, i.e. in cycle N+1. Minimum latency is 1 cycle.
- Throughput: 1 token/cycle sustained while 0 < count < Depth.
- Full: after the edge that raises `count` to Depth, `d_bp` is 1 in the next cycle. The first outgoing edge lowers `d_bp` in the cycle after it.
- Empty: after the edge that takes the last token, `q_valid` is 0 in the next cycle.
- Deassertion of resetn is synchronised externally. The first accept is possible on the first edge with resetn high.

## Test plan
- Reset: with resetn low, drive `d_valid` = 1 for 3 cycles. Expect `q_valid` = 0, `d_bp` = 0 and `count` = 0 throughout, with no token stored after release.
- Fill/drain (Depth=4, AlmostFull=3, Width=8): with `q_bp` = 1, push 0x11, 0x22, 0x33, 0x44. Expect:
  - `count` steps 1→4.
  - `almost_full` rises after the 3rd push.
  - `d_bp` = 1 after the 4th push.
  - A 5th offer of 0x55 is held off.
  - With `q_bp` = 0, output is 0x11, 0x22, 0x33, 0x44 on consecutive cycles, then `q_valid` = 0.
- Streaming: push 0x00..0x0F one per cycle with `q_bp` = 0. Expect output 0x00..0x0F in order, one per cycle after a 1-cycle latency, `count` ≤ 1 and `d_bp` never asserted.
- Wrap and stall: push 10 tokens while toggling `q_bp` on a random pattern. Expect in-order delivery across ≥ 2 pointer wraps, and `count` equal to pushes minus pops at every cycle.
- Full with stalled downstream: with the FIFO full, drop `q_bp` for one cycle while `d_valid` = 1. Expect one pop, no push in that cycle, and `count` = 3. Next cycle `d_bp` = 0, the held token is accepted and `count` returns to 4.
- Async reset mid-stream: with `count` = 2, assert resetn low between clock edges. Expect `q_valid` = 0 and `count` = 0 before the next edge. After release, a new push of 0xA5 is the next token out.
